pwm_multi_channel: RTL



---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_channel.sv | 42 ++++
 rtl/pwm_multi_channel.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared opcode map, command field positions and limits for the custom-instruction PWM controller.
package pwm_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_WR_ENABLE   = 4'd0;
    localparam opcode_t OP_WR_DUTY     = 4'd1;
    localparam opcode_t OP_WR_PERIOD   = 4'd2;
    localparam opcode_t OP_WR_POLARITY = 4'd3;
    localparam opcode_t OP_RD_DUTY     = 4'd4;
    localparam opcode_t OP_RD_PERIOD   = 4'd5;
    localparam opcode_t OP_RD_COUNTER  = 4'd6;
    localparam opcode_t OP_RD_STATUS   = 4'd7;
    localparam opcode_t OP_SYNC        = 4'd8;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 3;
    localparam int CH_LSB  = 8;
    localparam int CH_MSB  = 11;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: double-buffered duty, compare against the shared counter, enable/polarity, registered pin.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int COUNTER_WIDTH = 21
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_shadow,
    input  logic [COUNTER_WIDTH-1:0] shadow_data,
    input  logic                     transfer,
    input  logic [COUNTER_WIDTH-1:0] counter,
    input  logic                     enable,
    input  logic                     polarity,
    output logic [COUNTER_WIDTH-1:0] duty_active,
    output logic                     pin
);

    logic [COUNTER_WIDTH-1:0] r_duty_shadow;
    logic [COUNTER_WIDTH-1:0] r_duty_active;
    logic                     r_pin;
    logic                     w_raw;

    assign w_raw = (counter < r_duty_active);

    // transfer samples the shadow before a same-edge write lands, so such a write waits a period
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_duty_shadow <= '0;
            r_duty_active <= '0;
            r_pin         <= 1'b0;
        end else begin
            if (load_shadow) r_duty_shadow <= shadow_data;
            if (transfer)    r_duty_active <= r_duty_shadow;
            r_pin <= enable ? (w_raw ^ polarity) : polarity;
        end
    end

    assign duty_active = r_duty_active;
    assign pin         = r_pin;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM on the CPU custom-instruction bus: shared period counter, per-channel duty,
// shadow registers promoted at the period wrap or on SYNC, zero-latency register readback.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter logic [7:0] customId       = 8'h00,
    parameter int          NR_CHANNELS    = 4,
    parameter int          COUNTER_WIDTH  = 21,
    parameter int          DEFAULT_PERIOD = 1440000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             ciN,
    input  logic [31:0]            valueA,
    input  logic [31:0]            valueB,
    output logic [31:0]            result,
    output logic                   done,
    output logic [NR_CHANNELS-1:0] pwmPins
);

    localparam logic [COUNTER_WIDTH-1:0] RESET_PERIOD = COUNTER_WIDTH'(DEFAULT_PERIOD);
    localparam logic [COUNTER_WIDTH-1:0] PERIOD_FLOOR = COUNTER_WIDTH'(MIN_PERIOD);

    logic [COUNTER_WIDTH-1:0] r_counter;
    logic [COUNTER_WIDTH-1:0] r_period_shadow;
    logic [COUNTER_WIDTH-1:0] r_period_active;
    logic [NR_CHANNELS-1:0]   r_enable;
    logic [NR_CHANNELS-1:0]   r_polarity;

    logic                     w_hit;
    opcode_t                  w_opcode;
    logic [3:0]               w_ch;
    logic                     w_wr_duty;
    logic                     w_sync;
    logic                     w_wrap;
    logic                     w_transfer;
    logic [COUNTER_WIDTH-1:0] w_wdata;
    logic [COUNTER_WIDTH-1:0] w_period_wdata;
    logic [COUNTER_WIDTH-1:0] w_duty_active [NR_CHANNELS];
    logic [NR_CHANNELS-1:0]   w_pins;
    logic [31:0]              w_result;
    logic                     w_unused;

    assign w_hit      = start && (ciN == customId);
    assign w_opcode   = valueA[OPC_MSB:OPC_LSB];
    assign w_ch       = valueA[CH_MSB:CH_LSB];
    assign w_wdata    = valueB[COUNTER_WIDTH-1:0];
    assign w_wr_duty  = w_hit && (w_opcode == OP_WR_DUTY);
    assign w_sync     = w_hit && (w_opcode == OP_SYNC);
    assign w_wrap     = (r_counter == r_period_active - COUNTER_WIDTH'(1));
    assign w_transfer = w_sync || w_wrap;
    assign w_unused   = &{1'b0, valueA, valueB};

    // a period below 2 would make the counter wrap every cycle with no low phase
    assign w_period_wdata = (w_wdata < PERIOD_FLOOR) ? PERIOD_FLOOR : w_wdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_counter       <= '0;
            r_period_shadow <= RESET_PERIOD;
            r_period_active <= RESET_PERIOD;
            r_enable        <= '0;
            r_polarity      <= '0;
        end else begin
            if (w_hit && (w_opcode == OP_WR_ENABLE))   r_enable        <= valueB[NR_CHANNELS-1:0];
            if (w_hit && (w_opcode == OP_WR_POLARITY)) r_polarity      <= valueB[NR_CHANNELS-1:0];
            if (w_hit && (w_opcode == OP_WR_PERIOD))   r_period_shadow <= w_period_wdata;
            if (w_transfer) begin
                r_counter       <= '0;
                r_period_active <= r_period_shadow;
            end else begin
                r_counter <= r_counter + COUNTER_WIDTH'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NR_CHANNELS; gi++) begin : g_ch
            pwm_channel #(
                .COUNTER_WIDTH(COUNTER_WIDTH)
            ) u_channel (
                .clock       (clock),
                .reset       (reset),
                .load_shadow (w_wr_duty && (w_ch == 4'(gi))),
                .shadow_data (w_wdata),
                .transfer    (w_transfer),
                .counter     (r_counter),
                .enable      (r_enable[gi]),
                .polarity    (r_polarity[gi]),
                .duty_active (w_duty_active[gi]),
                .pin         (w_pins[gi])
            );
        end
    endgenerate

    always_comb begin
        w_result = '0;
        if (w_hit) begin
            case (w_opcode)
                OP_RD_DUTY: begin
                    for (int i = 0; i < NR_CHANNELS; i++) begin
                        if (w_ch == 4'(i)) w_result = 32'(w_duty_active[i]);
                    end
                end
                OP_RD_PERIOD:  w_result = 32'(r_period_active);
                OP_RD_COUNTER: w_result = 32'(r_counter);
                OP_RD_STATUS: begin
                    w_result[15:0]  = 16'(r_enable);
                    w_result[31:16] = 16'(r_polarity);
                end
                default: w_result = '0;
            endcase
        end
    end

    assign result  = w_result;
    assign done    = w_hit;
    assign pwmPins = w_pins;

endmodule
